// File: rtl/pipelined_acc_tree_pkg.sv
// Shared helpers for pipelined_acc_tree: lane count, lane sign extension and
// saturation bounds for the accumulator.
package pipelined_acc_tree_pkg;

    // Widest vector the helper functions operate on; OUT_BITWIDTH must not exceed it.
    localparam int unsigned MAX_W = 64;

    // Number of input lanes for a given log2 lane count.
    function automatic int unsigned num_lanes(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

    // Sign-extend the low from_width bits of value to MAX_W bits.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] value,
                                              input int unsigned     from_width);
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] upper_mask;
        shifted    = value >> (from_width - 32'd1);
        upper_mask = ~((MAX_W'(1) << from_width) - MAX_W'(1));
        if (shifted[0]) begin
            return value | upper_mask;
        end
        return value & ~upper_mask;
    endfunction

    // Largest positive value of a signed w-bit number, zero-extended.
    function automatic logic [MAX_W-1:0] sat_max(input int unsigned w);
        return (MAX_W'(1) << (w - 32'd1)) - MAX_W'(1);
    endfunction

    // Most negative value of a signed w-bit number (low w bits only).
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned w);
        return MAX_W'(1) << (w - 32'd1);
    endfunction

endpackage

// File: rtl/pipelined_acc_tree_level.sv
// One registered level of the adder tree: out[j] = in[2j] + in[2j+1], wrapping.
module pipelined_acc_tree_level
    import pipelined_acc_tree_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_IN-1:0][W-1:0]      i_in,
    output logic [N_IN/2-1:0][W-1:0]    o_out
);

    localparam int unsigned N_OUT = N_IN / 2;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [W-1:0] r_sum;

        // Pairwise sum of adjacent lanes, cleared by synchronous reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sum <= '0;
            end else begin
                r_sum <= i_in[2*j] + i_in[2*j+1];
            end
        end

        assign o_out[j] = r_sum;
    end

endmodule

// File: rtl/pipelined_acc_tree.sv
// Pipelined adder tree feeding a running-sum accumulator.
// Sums 2^LOG2_NO_IN signed lanes through LOG2_NO_IN registered levels, then
// loads (new_sum) or adds the tree result into the accumulator.
// Build option: define PIPELINED_ACC_TREE_SAT_EN to saturate the accumulator
// add instead of wrapping; tree adders and the load path always wrap.
module pipelined_acc_tree
    import pipelined_acc_tree_pkg::*;
#(
    parameter int unsigned IN_BITWIDTH  = 16,
    parameter int unsigned OUT_BITWIDTH = 16,
    parameter int unsigned LOG2_NO_IN   = 2
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             new_sum,
    input  logic [num_lanes(LOG2_NO_IN)*IN_BITWIDTH-1:0]     data_in,
    output logic [OUT_BITWIDTH-1:0]                          data_out
);

    localparam int unsigned NUM_LANES = num_lanes(LOG2_NO_IN);

    logic [NUM_LANES-1:0][OUT_BITWIDTH-1:0] w_lvl0;
    logic [OUT_BITWIDTH-1:0]                w_tree;
    logic                                   w_ns_al;
    logic [OUT_BITWIDTH-1:0]                w_acc_add;
    logic [OUT_BITWIDTH-1:0]                r_acc;

    // Level 0: each lane sign-extended to the accumulator width.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign w_lvl0[i] = OUT_BITWIDTH'(sext(MAX_W'(data_in[i*IN_BITWIDTH +: IN_BITWIDTH]),
                                              IN_BITWIDTH));
    end

    // Registered tree levels; level k halves the lane count of level k-1.
    for (genvar k = 1; k <= LOG2_NO_IN; k++) begin : g_lvl
        localparam int unsigned LVL_IN = NUM_LANES >> (k - 1);

        logic [LVL_IN-1:0][OUT_BITWIDTH-1:0]   w_in;
        logic [LVL_IN/2-1:0][OUT_BITWIDTH-1:0] w_out;

        if (k == 1) begin : g_first
            assign w_in = w_lvl0;
        end else begin : g_next
            assign w_in = g_lvl[k-1].w_out;
        end

        pipelined_acc_tree_level #(
            .N_IN (LVL_IN),
            .W    (OUT_BITWIDTH)
        ) u_level (
            .clk   (clk),
            .rst_n (rst_n),
            .i_in  (w_in),
            .o_out (w_out)
        );
    end

    // Tree result and new_sum aligned to it.
    if (LOG2_NO_IN == 0) begin : g_no_tree
        assign w_tree  = w_lvl0[0];
        assign w_ns_al = new_sum;
    end else begin : g_tree
        logic [LOG2_NO_IN-1:0] r_ns_dly;

        assign w_tree = g_lvl[LOG2_NO_IN].w_out[0];

        // new_sum delay line matching the tree depth.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_ns_dly <= '0;
            end else begin
                r_ns_dly <= LOG2_NO_IN'({r_ns_dly, new_sum});
            end
        end

        assign w_ns_al = r_ns_dly[LOG2_NO_IN-1];
    end

`ifdef PIPELINED_ACC_TREE_SAT_EN
    localparam logic [OUT_BITWIDTH-1:0] SAT_MAX = OUT_BITWIDTH'(sat_max(OUT_BITWIDTH));
    localparam logic [OUT_BITWIDTH-1:0] SAT_MIN = OUT_BITWIDTH'(sat_min(OUT_BITWIDTH));

    logic [OUT_BITWIDTH:0] w_sum_ext;

    // Accumulator add with one guard bit; clamp when the guard and sign bits disagree.
    always_comb begin
        w_sum_ext = {r_acc[OUT_BITWIDTH-1], r_acc} + {w_tree[OUT_BITWIDTH-1], w_tree};
        w_acc_add = w_sum_ext[OUT_BITWIDTH-1:0];
        if (w_sum_ext[OUT_BITWIDTH] != w_sum_ext[OUT_BITWIDTH-1]) begin
            w_acc_add = w_sum_ext[OUT_BITWIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_acc_add = r_acc + w_tree;
`endif

    // Accumulator: load on aligned new_sum, otherwise add the tree result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_ns_al) begin
            r_acc <= w_tree;
        end else begin
            r_acc <= w_acc_add;
        end
    end

    assign data_out = r_acc;

endmodule

// File: tb/tb_pipelined_acc_tree.sv
// Directed bench for pipelined_acc_tree: a 4-lane instance driven from a
// vector table plus hand sequences, and a single-lane instance.
module tb_pipelined_acc_tree;

    localparam int unsigned LAT = 2;   // edges after the sampling edge for 4 lanes

`ifdef PIPELINED_ACC_TREE_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'h8000;
    localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

    typedef struct {
        logic        ns;
        logic [63:0] lanes;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ns;
    logic [63:0] din;
    logic [15:0] dout;
    logic        s_ns;
    logic [15:0] s_din;
    logic [15:0] s_dout;

    int n_chk = 0;
    int n_err = 0;

    vec_t tab [20];

    always #5 clk = ~clk;

    pipelined_acc_tree #(
        .IN_BITWIDTH  (16),
        .OUT_BITWIDTH (16),
        .LOG2_NO_IN   (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_sum  (ns),
        .data_in  (din),
        .data_out (dout)
    );

    pipelined_acc_tree #(
        .IN_BITWIDTH  (16),
        .OUT_BITWIDTH (16),
        .LOG2_NO_IN   (0)
    ) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_sum  (s_ns),
        .data_in  (s_din),
        .data_out (s_dout)
    );

    function automatic vec_t mk(input logic n, input logic [15:0] l0, input logic [15:0] l1,
                                input logic [15:0] l2, input logic [15:0] l3,
                                input logic [15:0] e);
        vec_t v;
        v.ns    = n;
        v.lanes = {l3, l2, l1, l0};
        v.exp   = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(input logic n, input logic [63:0] lanes);
        ns  = n;
        din = lanes;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Stream of samples; exp is the data_out value once that sample lands.
        tab[0]  = mk(1'b1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd4);
        tab[1]  = mk(1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd8);
        tab[2]  = mk(1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd12);
        tab[3]  = mk(1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd16);
        tab[4]  = mk(1'b1, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFF6);
        tab[5]  = mk(1'b1, 16'h7FFF, 16'd1, 16'd0, 16'd0, 16'h8000);
        tab[6]  = mk(1'b1, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'h7FFF);
        tab[7]  = mk(1'b0, 16'd1, 16'd0, 16'd0, 16'd0, EXP_POS_OVF);
        tab[8]  = mk(1'b1, 16'h8000, 16'd0, 16'd0, 16'd0, 16'h8000);
        tab[9]  = mk(1'b0, 16'hFFFF, 16'd0, 16'd0, 16'd0, EXP_NEG_OVF);
        for (int k = 1; k <= 8; k++) begin
            tab[9+k] = mk(1'b1, 16'(k), 16'(k), 16'(k), 16'(k), 16'(4*k));
        end
        tab[18] = mk(1'b1, 16'd100, 16'hFFCE, 16'd25, 16'hFFB5, 16'd0);
        tab[19] = mk(1'b0, 16'h4000, 16'h4000, 16'd0, 16'd0, 16'h8000);

        // Reset held for two edges with non-zero lanes.
        rst_n = 1'b0;
        drive(1'b1, {16'd5, 16'd5, 16'd5, 16'd5});
        s_ns  = 1'b1;
        s_din = 16'd5;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("reset_out", dout, 16'd0);
            check("reset_out_1lane", s_dout, 16'd0);
        end

        // First sample after release: {1,2,3,4} -> 10 on the third edge.
        rst_n = 1'b1;
        s_ns  = 1'b0;
        s_din = 16'd0;
        drive(1'b1, {16'd4, 16'd3, 16'd2, 16'd1});
        tick();
        check("first_lat_e0", dout, 16'd0);
        drive(1'b0, 64'd0);
        tick();
        check("first_lat_e1", dout, 16'd0);
        tick();
        check("first_lat_e2", dout, 16'd10);

        // Table: drive one sample per cycle, check each one LAT edges later.
        for (int j = 0; j < 20 + int'(LAT); j++) begin
            if (j < 20) drive(tab[j].ns, tab[j].lanes);
            else        drive(1'b0, 64'd0);
            tick();
            if (j >= int'(LAT)) begin
                check($sformatf("vec%0d", j - int'(LAT)), dout, tab[j - int'(LAT)].exp);
            end
        end

        // Mid-operation reset discards an in-flight load of 36.
        drive(1'b1, {16'd9, 16'd9, 16'd9, 16'd9});
        tick();
        rst_n = 1'b0;
        drive(1'b1, {16'd5, 16'd5, 16'd5, 16'd5});
        tick();
        check("midrst_clear", dout, 16'd0);
        rst_n = 1'b1;
        drive(1'b0, {16'd0, 16'd0, 16'd0, 16'd1});
        tick();
        check("midrst_c0", dout, 16'd0);
        drive(1'b0, {16'd0, 16'd0, 16'd0, 16'd2});
        tick();
        check("midrst_c1", dout, 16'd0);
        drive(1'b0, 64'd0);
        tick();
        check("midrst_acc1", dout, 16'd1);
        tick();
        check("midrst_acc3", dout, 16'd3);
        tick();
        check("midrst_hold", dout, 16'd3);

        // Single-lane instance: latency of one edge.
        check("one_lane_idle", s_dout, 16'd0);
        s_ns  = 1'b1;
        s_din = 16'd7;
        tick();
        check("one_lane_load", s_dout, 16'd7);
        s_ns  = 1'b0;
        s_din = 16'd3;
        tick();
        check("one_lane_add", s_dout, 16'd10);
        s_din = 16'hFFFE;
        tick();
        check("one_lane_neg", s_dout, 16'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipelined_acc_tree.md
Name: pipelined_acc_tree

Overview:
- Sums 2^LOG2_NO_IN signed input lanes through a registered binary adder tree.
- Accumulates the tree result across cycles into a running sum.
- A new_sum strobe restarts the running sum.
- Sits behind the per-lane multiplier registers of the fixed-point multiply-accumulate datapath; the caller slices the output to its final width.

Parameters:
- IN_BITWIDTH, 16, width of each signed input lane.
- OUT_BITWIDTH, 16, width of the signed accumulator and output; must be >= IN_BITWIDTH.
- LOG2_NO_IN, 2, log2 of the lane count; lane count N = 2^LOG2_NO_IN; legal range 0..6.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- new_sum  input  1  the data_in sampled this cycle starts a fresh sum.
- data_in  input  N x IN_BITWIDTH  packed lanes, lane i at [i]; all signed two's complement.
- data_out  output  OUT_BITWIDTH  signed running sum (accumulator register).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: at a clk edge with rst_n=0, the following clear to 0:
  - all tree stage registers;
  - the new_sum delay line;
  - the accumulator.
  - data_out reads 0 on the cycle after reset.
- Width rule: each lane is sign-extended to OUT_BITWIDTH. All tree and accumulator additions are OUT_BITWIDTH two's complement and wrap modulo 2^OUT_BITWIDTH. No internal growth bits.
- Tree:
  - LOG2_NO_IN registered levels. Level k (k=1..LOG2_NO_IN) holds N/2^k registers.
  - Each register is the sum of two adjacent registers of level k-1: 2j and 2j+1. Level 0 is the sign-extended data_in (combinational, not registered).
  - Tree result T = the single level-LOG2_NO_IN register, valid LOG2_NO_IN cycles after the input sample.
  - LOG2_NO_IN=0: T is sign-extended data_in[0] directly, with no tree registers.
- new_sum alignment: new_sum is delayed through LOG2_NO_IN registers so it reaches the accumulator stage with the T it was sampled alongside.
- Accumulator, registered every cycle:
  - aligned new_sum=1: acc <= T;
  - otherwise: acc <= acc + T.
- Latency:
  - data_out reflects a sample LOG2_NO_IN+1 cycles after the edge at which data_in/new_sum were sampled.
  - Fully pipelined; a new sample is accepted every cycle; no stall or valid handshake.
- Continuous accumulation: with new_sum held 0, the sum keeps growing and wraps silently.
- new_sum held 1 every cycle: data_out equals the delayed per-sample lane sum.
- Reset mid-operation: in-flight samples and their new_sum flags are discarded. After release, accumulation continues from 0 until the next new_sum.

Optional Feature:
- Macro: PIPELINED_ACC_TREE_SAT_EN.
- Defined:
  - The accumulator add (acc + T) saturates to the signed OUT_BITWIDTH range instead of wrapping.
    - Positive overflow -> 2^(OUT_BITWIDTH-1)-1.
    - Negative overflow -> -2^(OUT_BITWIDTH-1).
  - The load path (new_sum) is unchanged.
  - Tree adders still wrap.
- Undefined: pure wrapping arithmetic everywhere.
- Latency is identical in both builds.

Decomposition:
- Shared package pipelined_acc_tree_pkg holds:
  - function num_lanes(log2) returning 1<<log2;
  - function sext(value, from_width) used for the lane extension;
  - saturation bound constants computed from OUT_BITWIDTH.
- One sub-module, pipelined_acc_tree_level: one registered adder-tree level. Parameters: lane count in and width. Ports: clk, rst_n, in vector, out vector.
- The top generates LOG2_NO_IN instances plus the new_sum delay line and accumulator.

Test Plan:
- Reset: rst_n=0 for 2 cycles with data_in lanes all 5 -> data_out=0. After release with new_sum=1 and lanes {1,2,3,4}, data_out=10 exactly 3 cycles later (LOG2_NO_IN=2).
- Accumulation: new_sum=1 with lanes {1,1,1,1}, then three cycles new_sum=0 with {1,1,1,1} -> data_out sequence 4, 8, 12, 16 starting at latency 3.
- Restart: running sum 16, then new_sum=1 with {-1,-2,-3,-4} -> data_out=-10 (0xFFF6) on the aligned cycle, not 6.
- Wrap (macro off), IN=OUT=16: new_sum=1 with {0x7FFF,1,0,0} -> data_out=0x8000. Saturation build with acc=0x7FFF plus T=1 -> data_out stays 0x7FFF.
- Back-to-back: new_sum=1 every cycle with lanes ramping k,k,k,k for k=1..8 -> data_out=4k each cycle, proving one sample per cycle throughput.
- LOG2_NO_IN=0, single lane: new_sum=1 with 7, then 0 with 3 -> data_out 7 then 10, latency 1.
